dcache_ctrl: RTL
================

// Module: dcache_ctrl
// PURPOSE
//  Data-memory controller downstream of the store queue and load FU. Drains retired
//  stores from the SQ write-through to memory. Services one load at a time:
//  direct-mapped D$ hit, or blocking miss to the tagged memory bus with line fill.
//  Owns the single proc2mem port, arbitrating load misses against SQ store drain.
// PARAMETERS
//  NUM_LINES  32  D$ lines (power of 2); one 64-bit word per line
//  IDX_W      5   log2(NUM_LINES); D$ tag = ADDR[ADDR_W-1:3+IDX_W]
// PORTS
//  clk                        in   1      clock
//  reset                      in   1      synchronous, active-high
//  sq_mem_en                  in   1      SQ head store retired, ready to drain
//  sq_mem_addr                in   ADDR   store byte address (8B aligned)
//  sq_mem_data                in   DATA   store data
//  dcachectrl_st_request_sent out  1      store accepted by memory this cycle
//  ld_req_valid               in   1      load FU request (no SQ forward match)
//  ld_req_addr                in   ADDR   load address
//  ld_req_prn                 in   PRN    destination physical register
//  br_pred_wrong              in   1      squash in-flight load
//  ld_busy                    out  1      controller cannot accept a load
//  ld_done_valid              out  1      load result valid
//  ld_done_data               out  DATA   load data
//  ld_done_prn                out  PRN    load destination
//  proc2mem_command           out  BUS_CMD  BUS_NONE/BUS_LOAD/BUS_STORE
//  proc2mem_addr              out  ADDR   memory address
//  proc2mem_data              out  DATA   store data
//  mem2proc_response          in   MEM_TAG  nonzero = command accepted, tag id
//  mem2proc_data              in   DATA   load return data
//  mem2proc_tag               in   MEM_TAG  tag of returning load (0 = none)
// BEHAVIOUR
//  Reset: state IDLE, all valid bits 0, all outputs 0, proc2mem_command=BUS_NONE.
//  FSM: IDLE, LD_REQ, LD_WAIT. ld_busy = (state!=IDLE).
//  IDLE + ld_req_valid & !br_pred_wrong: combinational D$ lookup.
//   hit  -> ld_done_* registered, valid next cycle; stay IDLE.
//   miss -> latch addr/prn, drive BUS_LOAD same cycle; response!=0 -> latch tag,
//           LD_WAIT; else -> LD_REQ (re-drive BUS_LOAD each cycle until accepted).
//  LD_WAIT: mem2proc_tag==saved tag (nonzero) -> fill line (valid=1, tag, data)
//   unless no_alloc set; ld_done next cycle unless squashed; -> IDLE.
//  Store drain: BUS_STORE driven when sq_mem_en and bus not used by a load this
//   cycle (IDLE w/o miss, or LD_WAIT). st_request_sent = BUS_STORE & response!=0.
//   Accepted store that hits D$ line (valid & tag match) updates data at clock edge.
//  Priority: load miss (IDLE miss, LD_REQ) > store; store retried next cycle.
//  Store accepted in LD_WAIT/LD_REQ whose line == pending miss line -> no_alloc=1
//   (fill data stale; returned to load, not written to D$). Cleared entering IDLE.
//  br_pred_wrong: IDLE -> request ignored; LD_REQ -> IDLE, no bus cmd that cycle;
//   LD_WAIT -> set squashed; keep waiting for tag; fill allowed, ld_done suppressed.
//   Same-cycle tag return + br_pred_wrong -> fill, no ld_done. Stores never squashed.
//  Load hit + store drain same cycle: both proceed; load reads pre-store value.
//  Reset mid-miss: FSM to IDLE, late memory returns ignored (saved tag cleared).
// STRUCTURE
//  Shared package: ADDR, DATA, PRN, MEM_TAG, BUS_CMD enum, DCACHE_LINES constant,
//   DCacheLine_t {valid, tag, data}.
//  Sub-module dcache_mem: direct-mapped arrays, 1 comb read port, 1 write port
//   (fill or store update; fill wins on same index, store hit then dropped from D$).
// TESTING
//  Cold load 0x100 -> miss, BUS_LOAD 0x100, resp=3, tag 3 returns 0xAB ->
//   ld_done data 0xAB next cycle; repeat load 0x100 -> hit, done 1 cycle, no bus cmd.
//  sq_mem_en 0x100/0x55 after fill, resp=2 -> st_request_sent=1, BUS_STORE; load 0x100
//   -> hit returns 0x55.
//  Load miss + sq_mem_en same cycle -> BUS_LOAD issued, st_request_sent=0; store sent
//   in LD_WAIT with resp!=0.
//  Miss with resp=0 for 3 cycles -> BUS_LOAD held 3 cycles, LD_REQ, ld_busy=1.
//  br_pred_wrong in LD_WAIT -> tag return fills line, ld_done_valid stays 0, IDLE.
//  Store to pending miss line during LD_WAIT -> fill not written; next load misses.

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// dcache_ctrl_pkg
//   Shared types and constants for the data-memory controller slice:
//   address/data/register/tag widths, the memory bus command encoding,
//   the D$ line record and the controller FSM state encoding.
// ----------------------------------------------------------------------------
package dcache_ctrl_pkg;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 64;
   localparam int PRN_W        = 6;
   localparam int MEM_TAG_W    = 4;
   localparam int DCACHE_LINES = 32;
   localparam int DC_IDX_W     = 5;
   // The tag field is sized for the smallest possible index so that the
   // line record stays valid for any NUM_LINES; unused upper bits are zero.
   localparam int TAG_FIELD_W  = ADDR_W - 3;

   typedef logic [ADDR_W-1:0]    ADDR;
   typedef logic [DATA_W-1:0]    DATA;
   typedef logic [PRN_W-1:0]     PRN;
   typedef logic [MEM_TAG_W-1:0] MEM_TAG;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } BUS_CMD;

   typedef struct packed {
      logic                   valid;
      logic [TAG_FIELD_W-1:0] tag;
      DATA                    data;
   } DCacheLine_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LD_REQ  = 2'd1,
      LD_WAIT = 2'd2
   } dc_state_e;

   // Line-granular address (one 64-bit word per line): drops the byte offset.
   function automatic logic [ADDR_W-4:0] line_addr(input ADDR addr);
      return addr[ADDR_W-1:3];
   endfunction

endpackage

// File: rtl/dcache_mem.sv
// ----------------------------------------------------------------------------
// dcache_mem
//   Direct-mapped D$ storage: valid/tag/data arrays, one combinational read
//   port and one write port carrying either a line fill or a store update.
//   A store only updates data when it hits (valid and tag match). A fill to
//   the same index wins and the store's cache update is dropped (the line is
//   being replaced anyway; the store itself still goes to memory).
// Ports
//   clk, reset          clock, synchronous active-high reset (clears valid)
//   rd_idx / rd_line    combinational lookup
//   fill_en/idx/tag/data  line allocate
//   st_en/idx/tag/data    accepted store, write-through update on hit
// ----------------------------------------------------------------------------
module dcache_mem
   import dcache_ctrl_pkg::*;
#(
   parameter int NUM_LINES = DCACHE_LINES,
   parameter int IDX_W     = DC_IDX_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [IDX_W-1:0]       rd_idx,
   output DCacheLine_t            rd_line,
   input  logic                   fill_en,
   input  logic [IDX_W-1:0]       fill_idx,
   input  logic [TAG_FIELD_W-1:0] fill_tag,
   input  DATA                    fill_data,
   input  logic                   st_en,
   input  logic [IDX_W-1:0]       st_idx,
   input  logic [TAG_FIELD_W-1:0] st_tag,
   input  DATA                    st_data
);

   logic                   valid_r [NUM_LINES];
   logic [TAG_FIELD_W-1:0] tag_r   [NUM_LINES];
   DATA                    data_r  [NUM_LINES];

   logic st_hit_s;
   logic st_write_s;

   // Combinational read port for the load lookup.
   always_comb begin
      rd_line.valid = valid_r[rd_idx];
      rd_line.tag   = tag_r[rd_idx];
      rd_line.data  = data_r[rd_idx];
   end

   // Store hit detection; a same-index fill takes the write.
   always_comb begin
      st_hit_s   = st_en & valid_r[st_idx] & (tag_r[st_idx] == st_tag);
      st_write_s = 1'b0;
      if (st_hit_s && !(fill_en && (fill_idx == st_idx))) begin
         st_write_s = 1'b1;
      end else begin
         st_write_s = 1'b0;
      end
   end

   // Valid bits: cleared on reset, set on fill.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            valid_r[i] <= 1'b0;
         end
      end else if (fill_en) begin
         valid_r[fill_idx] <= 1'b1;
      end
   end

   // Tag and data storage; contents are qualified by valid so no reset needed.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_r[fill_idx]  <= fill_tag;
         data_r[fill_idx] <= fill_data;
      end
      if (st_write_s) begin
         data_r[st_idx] <= st_data;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// ----------------------------------------------------------------------------
// dcache_ctrl
//   Data-memory controller between the SQ / load FU and the single proc2mem
//   port. Drains retired stores write-through; services one load at a time
//   as a D$ hit (result next cycle) or a blocking miss with line fill.
//   Load misses have priority on the bus; a blocked store simply retries.
// Ports
//   clk, reset                          clock, synchronous active-high reset
//   sq_mem_en/addr/data                 SQ head store ready to drain
//   dcachectrl_st_request_sent          store accepted by memory this cycle
//   ld_req_valid/addr/prn               load request from the load FU
//   br_pred_wrong                       squash the in-flight load
//   ld_busy                             controller cannot take a load
//   ld_done_valid/data/prn              registered load result
//   proc2mem_command/addr/data          memory bus request
//   mem2proc_response/data/tag          memory accept tag / load return
// ----------------------------------------------------------------------------
module dcache_ctrl
   import dcache_ctrl_pkg::*;
#(
   parameter int NUM_LINES = DCACHE_LINES,
   parameter int IDX_W     = DC_IDX_W
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   sq_mem_en,
   input  ADDR    sq_mem_addr,
   input  DATA    sq_mem_data,
   output logic   dcachectrl_st_request_sent,
   input  logic   ld_req_valid,
   input  ADDR    ld_req_addr,
   input  PRN     ld_req_prn,
   input  logic   br_pred_wrong,
   output logic   ld_busy,
   output logic   ld_done_valid,
   output DATA    ld_done_data,
   output PRN     ld_done_prn,
   output BUS_CMD proc2mem_command,
   output ADDR    proc2mem_addr,
   output DATA    proc2mem_data,
   input  MEM_TAG mem2proc_response,
   input  DATA    mem2proc_data,
   input  MEM_TAG mem2proc_tag
);

   dc_state_e state_r, next_state_s;
   ADDR       miss_addr_r;
   PRN        miss_prn_r;
   MEM_TAG    mem_tag_r;
   logic      no_alloc_r;
   logic      squashed_r;

   DCacheLine_t            rd_line_s;
   logic [TAG_FIELD_W-1:0] ld_tag_s;
   logic [TAG_FIELD_W-1:0] miss_tag_s;
   logic [TAG_FIELD_W-1:0] sq_tag_s;
   logic                   ld_go_s;
   logic                   ld_hit_s;
   logic                   store_ok_s;
   logic                   resp_ok_s;
   logic                   tag_back_s;
   logic                   st_sent_s;
   logic                   st_same_line_s;

   BUS_CMD cmd_s;
   ADDR    bus_addr_s;
   DATA    bus_data_s;
   logic   latch_miss_s;
   logic   latch_tag_s;
   logic   clear_miss_s;
   logic   set_squash_s;
   logic   fill_en_s;
   logic   done_valid_s;
   DATA    done_data_s;
   PRN     done_prn_s;

   // Address decode and request qualifiers.
   always_comb begin
      ld_tag_s   = TAG_FIELD_W'(ld_req_addr >> (3 + IDX_W));
      miss_tag_s = TAG_FIELD_W'(miss_addr_r >> (3 + IDX_W));
      sq_tag_s   = TAG_FIELD_W'(sq_mem_addr >> (3 + IDX_W));
      ld_go_s    = ld_req_valid & ~br_pred_wrong;
      ld_hit_s   = rd_line_s.valid & (rd_line_s.tag == ld_tag_s);
      resp_ok_s  = (mem2proc_response != MEM_TAG'(0));
      tag_back_s = (mem_tag_r != MEM_TAG'(0)) & (mem2proc_tag == mem_tag_r);
      // The bus is free for a store in IDLE without a miss, or in LD_WAIT.
      store_ok_s = ((state_r == IDLE) & ~(ld_go_s & ~ld_hit_s)) |
                   (state_r == LD_WAIT);
   end

   // Next-state, bus drive and load completion.
   always_comb begin
      next_state_s = state_r;
      cmd_s        = BUS_NONE;
      bus_addr_s   = ADDR'(0);
      bus_data_s   = DATA'(0);
      latch_miss_s = 1'b0;
      latch_tag_s  = 1'b0;
      clear_miss_s = 1'b0;
      set_squash_s = 1'b0;
      fill_en_s    = 1'b0;
      done_valid_s = 1'b0;
      done_data_s  = DATA'(0);
      done_prn_s   = PRN'(0);

      if (store_ok_s && sq_mem_en) begin
         cmd_s      = BUS_STORE;
         bus_addr_s = sq_mem_addr;
         bus_data_s = sq_mem_data;
      end else begin
         cmd_s = BUS_NONE;
      end
      st_sent_s = (cmd_s == BUS_STORE) & resp_ok_s;
      // A store landing on the outstanding miss line makes the fill stale.
      st_same_line_s = st_sent_s & (state_r != IDLE) &
                       (line_addr(sq_mem_addr) == line_addr(miss_addr_r));

      case (state_r)
         IDLE: begin
            if (ld_go_s && ld_hit_s) begin
               done_valid_s = 1'b1;
               done_data_s  = rd_line_s.data;
               done_prn_s   = ld_req_prn;
            end else if (ld_go_s) begin
               cmd_s        = BUS_LOAD;
               bus_addr_s   = ld_req_addr;
               bus_data_s   = DATA'(0);
               latch_miss_s = 1'b1;
               if (resp_ok_s) begin
                  latch_tag_s  = 1'b1;
                  next_state_s = LD_WAIT;
               end else begin
                  next_state_s = LD_REQ;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         LD_REQ: begin
            if (br_pred_wrong) begin
               cmd_s        = BUS_NONE;
               bus_addr_s   = ADDR'(0);
               bus_data_s   = DATA'(0);
               clear_miss_s = 1'b1;
               next_state_s = IDLE;
            end else begin
               cmd_s      = BUS_LOAD;
               bus_addr_s = miss_addr_r;
               bus_data_s = DATA'(0);
               if (resp_ok_s) begin
                  latch_tag_s  = 1'b1;
                  next_state_s = LD_WAIT;
               end else begin
                  next_state_s = LD_REQ;
               end
            end
         end
         LD_WAIT: begin
            set_squash_s = br_pred_wrong;
            if (tag_back_s) begin
               fill_en_s    = ~(no_alloc_r | st_same_line_s);
               done_valid_s = ~(squashed_r | br_pred_wrong);
               done_data_s  = mem2proc_data;
               done_prn_s   = miss_prn_r;
               clear_miss_s = 1'b1;
               next_state_s = IDLE;
            end else begin
               next_state_s = LD_WAIT;
            end
         end
         default: begin
            cmd_s        = BUS_NONE;
            clear_miss_s = 1'b1;
            next_state_s = IDLE;
         end
      endcase
   end

   // Bus and status outputs, forced idle while reset is asserted.
   always_comb begin
      if (reset) begin
         proc2mem_command           = BUS_NONE;
         proc2mem_addr              = ADDR'(0);
         proc2mem_data              = DATA'(0);
         dcachectrl_st_request_sent = 1'b0;
         ld_busy                    = 1'b0;
      end else begin
         proc2mem_command           = cmd_s;
         proc2mem_addr              = bus_addr_s;
         proc2mem_data              = bus_data_s;
         dcachectrl_st_request_sent = (cmd_s == BUS_STORE) & resp_ok_s;
         ld_busy                    = (state_r != IDLE);
      end
   end

   // FSM state and outstanding-miss bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         miss_addr_r <= ADDR'(0);
         miss_prn_r  <= PRN'(0);
         mem_tag_r   <= MEM_TAG'(0);
         no_alloc_r  <= 1'b0;
         squashed_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         if (latch_miss_s) begin
            miss_addr_r <= ld_req_addr;
            miss_prn_r  <= ld_req_prn;
         end
         if (latch_tag_s) begin
            mem_tag_r <= mem2proc_response;
         end else if (clear_miss_s) begin
            mem_tag_r <= MEM_TAG'(0);
         end
         if (clear_miss_s) begin
            no_alloc_r <= 1'b0;
            squashed_r <= 1'b0;
         end else begin
            if (st_same_line_s) begin
               no_alloc_r <= 1'b1;
            end
            if (set_squash_s) begin
               squashed_r <= 1'b1;
            end
         end
      end
   end

   // Registered load result.
   always_ff @(posedge clk) begin
      if (reset) begin
         ld_done_valid <= 1'b0;
         ld_done_data  <= DATA'(0);
         ld_done_prn   <= PRN'(0);
      end else begin
         ld_done_valid <= done_valid_s;
         ld_done_data  <= done_data_s;
         ld_done_prn   <= done_prn_s;
      end
   end

   dcache_mem #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W)
   ) u_dcache_mem (
      .clk       (clk),
      .reset     (reset),
      .rd_idx    (ld_req_addr[3 +: IDX_W]),
      .rd_line   (rd_line_s),
      .fill_en   (fill_en_s & ~reset),
      .fill_idx  (miss_addr_r[3 +: IDX_W]),
      .fill_tag  (miss_tag_s),
      .fill_data (mem2proc_data),
      .st_en     (st_sent_s & ~reset),
      .st_idx    (sq_mem_addr[3 +: IDX_W]),
      .st_tag    (sq_tag_s),
      .st_data   (sq_mem_data)
   );

endmodule
